avi_info_frame_parser: RTL

Receive-side counterpart of the HDMI Auxiliary Video Information (AVI) InfoFrame generator. It accepts a byte-serial InfoFrame packet: header bytes HB0–HB2, then packet bytes PB0–PB27. It validates type, version, length and checksum, then decodes the CEA-861 AVI fields into held registers. It sits after the data-island packet deserializer in the HDMI sink path and feeds video-format and aspect-ratio decisions to the scaler and colour-space logic.

---
 rtl/avi_info_frame_parser.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/avi_info_frame_parser.sv
// avi_info_frame_parser: byte-serial HDMI AVI InfoFrame receiver.
// Captures HB0..HB2 and PB0..PB27, validates type/version/length/checksum
// and publishes the decoded CEA-861 AVI fields as held registers.
`timescale 1ns/1ps
module avi_info_frame_parser #(
    parameter int unsigned MIN_VERSION = 2,
    parameter int unsigned MAX_VERSION = 4,
    parameter int unsigned MIN_LENGTH  = 13
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       have_info,
    output logic [1:0] video_format,
    output logic       active_format_present,
    output logic [1:0] bar_info,
    output logic [1:0] scan_info,
    output logic [1:0] colorimetry,
    output logic [1:0] picture_aspect,
    output logic [3:0] active_format_aspect,
    output logic       it_content,
    output logic [2:0] ext_colorimetry,
    output logic [1:0] rgb_quant,
    output logic [1:0] nonuniform_scaling,
    output logic [6:0] vic,
    output logic [1:0] ycc_quant,
    output logic [1:0] content_type,
    output logic [3:0] pixel_repetition
);

    localparam logic [7:0] MIN_VER = MIN_VERSION[7:0];
    localparam logic [7:0] MAX_VER = MAX_VERSION[7:0];
    localparam logic [4:0] MIN_LEN = MIN_LENGTH[4:0];
    localparam logic [4:0] MAX_LEN = 5'd27;
    localparam logic [4:0] LAST_IDX = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] idx;
    logic [7:0] csum;
    logic [7:0] hb0;
    logic [7:0] hb1;
    logic [4:0] len;
    logic [6:0] st_pb1;
    logic [7:0] st_pb2;
    logic [7:0] st_pb3;
    logic [6:0] st_pb4;
    logic [7:0] st_pb5;
    logic       accept;
    logic       csum_en;
    logic [2:0] err_sel;

    assign accept = in_valid && in_ready;

    // Bytes past PB[L] are excluded from the checksum. At idx 1..2 the bound
    // (len+3 >= 3) always admits the byte, so a stale len is harmless there.
    assign csum_en = ({1'b0, idx} <= ({1'b0, len} + 6'd3));

    // Validation result in priority order, evaluated while in CHECK.
    always_comb begin
        err_sel = 3'd0;
        if (hb0 != 8'h82)
            err_sel = 3'd1;
        else if ((hb1 < MIN_VER) || (hb1 > MAX_VER))
            err_sel = 3'd2;
        else if ((len < MIN_LEN) || (len > MAX_LEN))
            err_sel = 3'd3;
        else if (csum != 8'h00)
            err_sel = 3'd4;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: an interrupting sof keeps COLLECT alive.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept && in_sof) state_nxt = S_COLLECT;
            S_COLLECT: if (accept && !in_sof && (idx == LAST_IDX)) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: back-pressure only during the single CHECK cycle.
    always_comb begin
        in_ready = 1'b1;
        if (state == S_CHECK)
            in_ready = 1'b0;
    end

    // Byte capture, checksum accumulation, validation result and field update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx                   <= '0;
            csum                  <= '0;
            hb0                   <= '0;
            hb1                   <= '0;
            len                   <= '0;
            st_pb1                <= '0;
            st_pb2                <= '0;
            st_pb3                <= '0;
            st_pb4                <= '0;
            st_pb5                <= '0;
            frame_ok              <= 1'b0;
            frame_err             <= 1'b0;
            err_code              <= '0;
            have_info             <= 1'b0;
            video_format          <= '0;
            active_format_present <= 1'b0;
            bar_info              <= '0;
            scan_info             <= '0;
            colorimetry           <= '0;
            picture_aspect        <= '0;
            active_format_aspect  <= '0;
            it_content            <= 1'b0;
            ext_colorimetry       <= '0;
            rgb_quant             <= '0;
            nonuniform_scaling    <= '0;
            vic                   <= '0;
            ycc_quant             <= '0;
            content_type          <= '0;
            pixel_repetition      <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && in_sof) begin
                        hb0  <= in_data;
                        csum <= in_data;
                        idx  <= 5'd1;
                    end
                end
                S_COLLECT: begin
                    if (accept && in_sof) begin
                        frame_err <= 1'b1;
                        err_code  <= 3'd5;
                        hb0       <= in_data;
                        csum      <= in_data;
                        idx       <= 5'd1;
                    end else if (accept) begin
                        case (idx)
                            5'd1:    hb1    <= in_data;
                            5'd2:    len    <= in_data[4:0];
                            5'd4:    st_pb1 <= in_data[6:0];
                            5'd5:    st_pb2 <= in_data;
                            5'd6:    st_pb3 <= in_data;
                            5'd7:    st_pb4 <= in_data[6:0];
                            5'd8:    st_pb5 <= in_data;
                            default: ;
                        endcase
                        if (csum_en)
                            csum <= csum + in_data;
                        if (idx == LAST_IDX)
                            idx <= '0;
                        else
                            idx <= idx + 5'd1;
                    end
                end
                S_CHECK: begin
                    if (err_sel != 3'd0) begin
                        frame_err <= 1'b1;
                        err_code  <= err_sel;
                    end else begin
                        frame_ok              <= 1'b1;
                        have_info             <= 1'b1;
                        video_format          <= st_pb1[6:5];
                        active_format_present <= st_pb1[4];
                        bar_info              <= st_pb1[3:2];
                        scan_info             <= st_pb1[1:0];
                        colorimetry           <= st_pb2[7:6];
                        picture_aspect        <= st_pb2[5:4];
                        active_format_aspect  <= st_pb2[3:0];
                        it_content            <= st_pb3[7];
                        ext_colorimetry       <= st_pb3[6:4];
                        rgb_quant             <= st_pb3[3:2];
                        nonuniform_scaling    <= st_pb3[1:0];
                        vic                   <= st_pb4;
                        ycc_quant             <= st_pb5[7:6];
                        content_type          <= st_pb5[5:4];
                        pixel_repetition      <= st_pb5[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
